t_block_sched: RTL

- Sequencer that feeds per-joint Denavit-Hartenberg parameters (theta, alpha, a, d) into the fixed-latency t_block pipeline, one joint per cycle.
- Tracks in-flight joints with a tag shift register and captures each 4x4 transform into a result FIFO.
- Hands results to the downstream matrix-chain multiplier over a valid/ready handshake.
- t_block's internal delay lines are not clock-enabled, so t_block is never stalled; issue is credit-gated instead.

---
 rtl/t_sched_pkg.sv | 61 ++++++
 rtl/t_sched_fifo.sv | 73 +++++++
 rtl/t_block_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/t_sched_pkg.sv
// Shared types and constants for the t_block issue scheduler.
//   W          : fixed-point word width (8 fractional bits).
//   ONE        : fixed-point 1.0.
//   dh_field_e : selects one Denavit-Hartenberg field in the parameter table.
//   t_matrix_t : 4x4 transform, row-major, element [0][0] in the LSBs.
//   tag_t      : in-flight marker travelling alongside the t_block pipeline.
//   dh_t       : one joint's DH parameter set.
//   result_t   : one entry of the result FIFO.
package t_sched_pkg;

  localparam int W = 27;
  localparam logic [W-1:0] ONE = W'(256);

  typedef enum logic [1:0] {
    THETA = 2'd0,
    ALPHA = 2'd1,
    A     = 2'd2,
    D     = 2'd3
  } dh_field_e;

  typedef logic [3:0][3:0][W-1:0] t_matrix_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] joint;
    logic       last;
  } tag_t;

  typedef struct packed {
    logic [W-1:0] theta;
    logic [W-1:0] alpha;
    logic [W-1:0] a;
    logic [W-1:0] d;
  } dh_t;

  typedef struct packed {
    t_matrix_t  matrix;
    logic [2:0] joint;
    logic       last;
  } result_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  // Returns row with the selected field replaced by v.
  function automatic dh_t dh_set_field(dh_t row, dh_field_e f, logic [W-1:0] v);
    dh_t r;
    r = row;
    case (f)
      THETA:   r.theta = v;
      ALPHA:   r.alpha = v;
      A:       r.a     = v;
      default: r.d     = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/t_sched_fifo.sv
// First-word-fall-through FIFO with occupancy count.
//   clk, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i       : write wdata_i (ignored when full unless popping)
//   wdata_i      : entry to write
//   pop_i        : remove head (ignored when empty)
//   rdata_o      : head entry, valid when valid_o
//   valid_o      : FIFO not empty
//   count_o      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module t_sched_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full FIFO is only allowed when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is defined by the pointers and count, so resetting the data would only cost a reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/t_block_sched.sv
// Issue sequencer for the fixed-latency t_block DH-transform pipeline.
// Joint parameters are held in a small table, fed to t_block one joint per
// cycle, tracked by a tag shift register that mirrors the pipeline depth and
// captured into a result FIFO read by the matrix-chain multiplier.
//   clk, reset_n          : clock, synchronous active-low reset
//   cfg_we/joint/field/data, cfg_ready : parameter table write port (IDLE only)
//   start, num_joints     : begin a run of 1..JOINTS joints
//   busy, done            : run in progress / one-cycle completion pulse
//   tb_en, tb_theta/alpha/a/d : t_block inputs
//   tb_t_matrix           : t_block output
//   res_valid/ready, res_matrix/joint/last : result handshake to the consumer
// JOINTS must not exceed 7 (3-bit joint index); LATENCY must equal the t_block
// pipeline depth and be at least 2.
module t_block_sched
  import t_sched_pkg::*;
#(
  parameter int JOINTS     = 6,
  parameter int LATENCY    = 27,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_joint,
  input  logic [1:0]        cfg_field,
  input  logic [W-1:0]      cfg_data,
  output logic              cfg_ready,
  input  logic              start,
  input  logic [2:0]        num_joints,
  output logic              busy,
  output logic              done,
  output logic              tb_en,
  output logic [W-1:0]      tb_theta,
  output logic [W-1:0]      tb_alpha,
  output logic [W-1:0]      tb_a,
  output logic [W-1:0]      tb_d,
  input  logic [16*W-1:0]   tb_t_matrix,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [16*W-1:0]   res_matrix,
  output logic [2:0]        res_joint,
  output logic              res_last
);

  localparam int         CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int         INF_W = $clog2(LATENCY + 1);
  localparam logic [2:0] MAX_N = 3'(JOINTS);

  state_e             state_q, state_d;
  logic [2:0]         n_q, n_d;
  logic [2:0]         k_q, k_d;
  logic               done_q, done_d;
  dh_t                dh_q, dh_d;
  dh_t                tbl_q [JOINTS];
  tag_t [LATENCY-1:0] tag_q;
  tag_t               new_tag, exit_tag;
  logic [INF_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_valid;
  logic               can_issue, pop;
  result_t            push_data, head;

  assign exit_tag  = tag_q[LATENCY-1];
  // Every valid tag owns a future FIFO slot, so reserving count+inflight
  // guarantees a capture never finds the FIFO full.
  assign can_issue = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
  assign pop       = fifo_valid && res_ready;

  // Table survives reset; a write lands before any run that starts next cycle.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ready && (int'(cfg_joint) < JOINTS))
      tbl_q[cfg_joint] <= dh_set_field(tbl_q[cfg_joint], dh_field_e'(cfg_field), cfg_data);
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    done_d  = 1'b0;
    dh_d    = dh_q;
    new_tag = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_joints == 3'd0)     n_d = 3'd1;
          else if (num_joints > MAX_N) n_d = MAX_N;
          else                         n_d = num_joints;
          k_d     = 3'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // t_block cannot stall, so a cycle without credit simply sends an
        // invalid tag down the line while the inputs hold their last value.
        if (can_issue) begin
          dh_d          = tbl_q[k_q];
          new_tag.valid = 1'b1;
          new_tag.joint = k_q;
          new_tag.last  = (k_q == n_q - 3'd1);
          k_d           = k_q + 3'd1;
          if (new_tag.last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head.last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inflight_d = inflight_q + INF_W'(new_tag.valid) - INF_W'(exit_tag.valid);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      n_q        <= 3'd1;
      k_q        <= 3'd0;
      done_q     <= 1'b0;
      dh_q       <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      done_q     <= done_d;
      dh_q       <= dh_d;
      tag_q      <= {tag_q[LATENCY-2:0], new_tag};
      inflight_q <= inflight_d;
    end
  end

  // The tag leaving the shift register lines up with the t_block output of
  // the same joint, so the capture happens in that very cycle.
  assign push_data.matrix = tb_t_matrix;
  assign push_data.joint  = exit_tag.joint;
  assign push_data.last   = exit_tag.last;

  t_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(result_t))
  ) u_res_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (exit_tag.valid),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  // Issue data is presented in the issue cycle itself so t_block samples it
  // on the same edge that pushes the matching tag.
  assign tb_en      = 1'b1;
  assign tb_theta   = dh_d.theta;
  assign tb_alpha   = dh_d.alpha;
  assign tb_a       = dh_d.a;
  assign tb_d       = dh_d.d;
  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign res_valid  = fifo_valid;
  assign res_matrix = head.matrix;
  assign res_joint  = head.joint;
  assign res_last   = head.last;

endmodule
